// File: rtl/ariane_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ariane_pkg
//  Description : Shared types for the frontend next-PC generator.
//                - npc_state_e : fetch sequencer states (BOOT/REQ/WAIT/DROP)
//                - npc_pred_t  : per-block prediction result {valid, slot, target}
//                - fetch_bytes : bytes per fetch block for a given slot count
//                The struct fields are sized for the largest supported
//                configuration (up to 256 slots, up to 64-bit addresses);
//                users slice off the bits they need.
//  Revision    : 1.0 - initial release
// ============================================================================
package ariane_pkg;

    localparam int unsigned DEFAULT_INSTR_PER_FETCH = 2;
    localparam int unsigned PRED_SLOT_W             = 8;
    localparam int unsigned PRED_TARGET_W           = 64;

    // Each slot is a 16-bit parcel, so a block spans two bytes per slot.
    function automatic int unsigned fetch_bytes(input int unsigned ipf);
        return 2 * ipf;
    endfunction

    localparam int unsigned FETCH_BYTES = fetch_bytes(DEFAULT_INSTR_PER_FETCH);

    typedef enum logic [1:0] {
        NPC_BOOT = 2'd0,
        NPC_REQ  = 2'd1,
        NPC_WAIT = 2'd2,
        NPC_DROP = 2'd3
    } npc_state_e;

    typedef struct packed {
        logic                     valid;
        logic [PRED_SLOT_W-1:0]   slot;
        logic [PRED_TARGET_W-1:0] target;
    } npc_pred_t;

endpackage
`default_nettype wire

// File: rtl/npc_slot_scan.sv
`default_nettype none
// ============================================================================
//  Module      : npc_slot_scan
//  Description : Combinational scan of a returned fetch block. Masks slots
//                that lie before the (possibly unaligned) fetch start, then
//                picks the lowest-indexed slot holding a jalr with a valid
//                BTB entry. Predictions are suppressed in debug mode.
//  Ports       : pc_off_i     - byte offset of the fetch PC within its block
//                debug_mode_i - suppress all predictions
//                is_jalr_i    - predecode, one bit per slot
//                btb_valid_i  - BTB hit, one bit per slot
//                btb_target_i - BTB targets, slot i at [i*VLEN +: VLEN]
//                pred_o       - winning slot, its target, and a valid flag
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_slot_scan
    import ariane_pkg::*;
#(
    parameter  int unsigned INSTR_PER_FETCH = 2,
    parameter  int unsigned VLEN            = 64,
    localparam int unsigned OFF_W           = $clog2(fetch_bytes(INSTR_PER_FETCH))
) (
    input  logic [OFF_W-1:0]                pc_off_i,
    input  logic                            debug_mode_i,
    input  logic [INSTR_PER_FETCH-1:0]      is_jalr_i,
    input  logic [INSTR_PER_FETCH-1:0]      btb_valid_i,
    input  logic [INSTR_PER_FETCH*VLEN-1:0] btb_target_i,
    output npc_pred_t                       pred_o
);

    logic [INSTR_PER_FETCH-1:0] w_taken;

    // A slot is live when its byte offset is at or beyond the fetch start.
    // Comparing offsets inside the block is the same as comparing full
    // addresses, since a block never straddles an aligned boundary.
    for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_slot
        localparam logic [OFF_W-1:0] c_SLOT_OFF = OFF_W'(2 * i);
        assign w_taken[i] = (c_SLOT_OFF >= pc_off_i) & is_jalr_i[i]
                          & btb_valid_i[i] & ~debug_mode_i;
    end

    // Walk from the highest slot down so the lowest taken slot is the last
    // (and therefore winning) assignment.
    always_comb begin
        pred_o = '0;
        for (int i = INSTR_PER_FETCH - 1; i >= 0; i--) begin
            if (w_taken[i]) begin
                pred_o.valid  = 1'b1;
                pred_o.slot   = PRED_SLOT_W'(i);
                pred_o.target = PRED_TARGET_W'(btb_target_i[i*VLEN +: VLEN]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/frontend_npc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frontend_npc_gen
//  Description : Next-PC generator and fetch sequencer. Issues one fetch
//                request at a time, waits for its response, forwards the
//                block (with any predicted-taken jalr) to the instruction
//                queue and steers the next fetch address. Backend redirects
//                override everything; a response belonging to a fetch that
//                was overtaken by a redirect is swallowed.
//  Ports       : clk_i, rst_ni (async, active low)
//                debug_mode_i                 - sequential fetch only
//                redirect_valid_i/addr_i      - backend redirect
//                fetch_req_o/vaddr_o/gnt_i    - request to I-cache and BTB
//                rsp_valid_i                  - data for the granted fetch
//                is_jalr_i/btb_valid_i/btb_target_i - per-slot prediction
//                iq_ready_i/iq_valid_o/iq_vaddr_o/iq_pred_*_o - to the IQ
//  Options     : FRONTEND_NPC_GEN_PERF_EN adds saturating 32-bit counters
//                perf_redirect_o, perf_pred_taken_o, perf_replay_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module frontend_npc_gen
    import ariane_pkg::*;
#(
    parameter  int unsigned INSTR_PER_FETCH = 2,
    parameter  logic [63:0] BOOT_ADDR       = 64'h0000_0000_8000_0000,
    parameter  int unsigned VLEN            = 64,
    localparam int unsigned SLOT_W          = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            debug_mode_i,
    input  logic                            redirect_valid_i,
    input  logic [VLEN-1:0]                 redirect_addr_i,
    output logic                            fetch_req_o,
    output logic [VLEN-1:0]                 fetch_vaddr_o,
    input  logic                            fetch_gnt_i,
    input  logic                            rsp_valid_i,
    input  logic [INSTR_PER_FETCH-1:0]      is_jalr_i,
    input  logic [INSTR_PER_FETCH-1:0]      btb_valid_i,
    input  logic [INSTR_PER_FETCH*VLEN-1:0] btb_target_i,
    input  logic                            iq_ready_i,
    output logic                            iq_valid_o,
    output logic [VLEN-1:0]                 iq_vaddr_o,
    output logic                            iq_pred_valid_o,
    output logic [SLOT_W-1:0]               iq_pred_slot_o,
    output logic [VLEN-1:0]                 iq_pred_target_o
`ifdef FRONTEND_NPC_GEN_PERF_EN
    ,
    output logic [31:0]                     perf_redirect_o,
    output logic [31:0]                     perf_pred_taken_o,
    output logic [31:0]                     perf_replay_o
`endif
);

    localparam int unsigned c_FETCH_BYTES = fetch_bytes(INSTR_PER_FETCH);
    localparam int unsigned c_OFF_W       = $clog2(c_FETCH_BYTES);

    npc_state_e       state_q;
    npc_state_e       w_state_next;
    logic [VLEN-1:0]  pc_q;
    logic [VLEN-1:0]  w_pc_next;
    logic [VLEN-1:0]  w_seq_npc;
    logic [VLEN-1:0]  w_npc;
    logic             w_accept;
    logic             w_replay;
    npc_pred_t        w_pred;
    logic             w_unused_pred;

    // ------------------------------------------------------------------
    // Block scan and next-PC selection
    // ------------------------------------------------------------------
    npc_slot_scan #(
        .INSTR_PER_FETCH (INSTR_PER_FETCH),
        .VLEN            (VLEN)
    ) u_slot_scan (
        .pc_off_i     (pc_q[c_OFF_W-1:0]),
        .debug_mode_i (debug_mode_i),
        .is_jalr_i    (is_jalr_i),
        .btb_valid_i  (btb_valid_i),
        .btb_target_i (btb_target_i),
        .pred_o       (w_pred)
    );

    // Sequential successor: aligned base of the current block plus one block.
    // Wraps naturally at the top of the address space.
    assign w_seq_npc = {pc_q[VLEN-1:c_OFF_W], c_OFF_W'(0)} + VLEN'(c_FETCH_BYTES);
    assign w_npc     = w_pred.valid ? w_pred.target[VLEN-1:0] : w_seq_npc;

    // The package struct is sized for the widest configuration.
    assign w_unused_pred = ^{w_pred.slot, w_pred.target};

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= NPC_BOOT;
            pc_q    <= BOOT_ADDR[VLEN-1:0];
        end else begin
            state_q <= w_state_next;
            pc_q    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = state_q;
        w_pc_next    = pc_q;
        w_accept     = 1'b0;
        w_replay     = 1'b0;
        case (state_q)
            NPC_BOOT: begin
                w_state_next = NPC_REQ;
                if (redirect_valid_i) begin
                    w_pc_next = redirect_addr_i;
                end
            end
            NPC_REQ: begin
                if (redirect_valid_i) begin
                    // A granted request now targets a stale address; its
                    // response must be swallowed.
                    w_pc_next    = redirect_addr_i;
                    w_state_next = fetch_gnt_i ? NPC_DROP : NPC_REQ;
                end else if (fetch_gnt_i) begin
                    w_state_next = NPC_WAIT;
                end
            end
            NPC_WAIT: begin
                if (redirect_valid_i) begin
                    w_pc_next    = redirect_addr_i;
                    w_state_next = rsp_valid_i ? NPC_REQ : NPC_DROP;
                end else if (rsp_valid_i) begin
                    w_state_next = NPC_REQ;
                    if (iq_ready_i) begin
                        w_accept  = 1'b1;
                        w_pc_next = w_npc;
                    end else begin
                        // Queue full: drop the block and refetch the same pc.
                        w_replay = 1'b1;
                    end
                end
            end
            NPC_DROP: begin
                if (redirect_valid_i) begin
                    w_pc_next = redirect_addr_i;
                end
                if (rsp_valid_i) begin
                    w_state_next = NPC_REQ;
                end
            end
            default: begin
                w_state_next = NPC_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: IQ fields are zeroed whenever no block is accepted
    // ------------------------------------------------------------------
    assign fetch_req_o      = (state_q == NPC_REQ);
    assign fetch_vaddr_o    = pc_q;
    assign iq_valid_o       = w_accept;
    assign iq_vaddr_o       = w_accept ? pc_q : '0;
    assign iq_pred_valid_o  = w_accept & w_pred.valid;
    assign iq_pred_slot_o   = (w_accept & w_pred.valid) ? w_pred.slot[SLOT_W-1:0] : '0;
    assign iq_pred_target_o = (w_accept & w_pred.valid) ? w_pred.target[VLEN-1:0] : '0;

`ifdef FRONTEND_NPC_GEN_PERF_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [31:0] r_perf_redirect;
    logic [31:0] r_perf_pred_taken;
    logic [31:0] r_perf_replay;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_redirect   <= '0;
            r_perf_pred_taken <= '0;
            r_perf_replay     <= '0;
        end else begin
            if (redirect_valid_i && (r_perf_redirect != '1)) begin
                r_perf_redirect <= r_perf_redirect + 32'd1;
            end
            if (w_accept && w_pred.valid && (r_perf_pred_taken != '1)) begin
                r_perf_pred_taken <= r_perf_pred_taken + 32'd1;
            end
            if (w_replay && (r_perf_replay != '1)) begin
                r_perf_replay <= r_perf_replay + 32'd1;
            end
        end
    end

    assign perf_redirect_o   = r_perf_redirect;
    assign perf_pred_taken_o = r_perf_pred_taken;
    assign perf_replay_o     = r_perf_replay;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frontend_npc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frontend_npc_gen
//  Description : Self-checking bench for frontend_npc_gen. A transaction-
//                level model (booting / requesting / response outstanding /
//                outstanding response is stale) predicts every output each
//                cycle; directed scenarios pin the model with literal values,
//                then a randomized run exercises all interleavings.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frontend_npc_gen;

    localparam int unsigned IPF  = 2;
    localparam int unsigned VLEN = 64;
    localparam logic [63:0] BOOT = 64'h0000_0000_8000_0000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                debug_mode;
    logic                redirect;
    logic [VLEN-1:0]     raddr;
    logic                fetch_req;
    logic [VLEN-1:0]     fetch_vaddr;
    logic                gnt;
    logic                rsp;
    logic [IPF-1:0]      is_jalr;
    logic [IPF-1:0]      btb_valid;
    logic [IPF*VLEN-1:0] btb_target;
    logic                ready;
    logic                iq_valid;
    logic [VLEN-1:0]     iq_vaddr;
    logic                iq_pred_valid;
    logic [0:0]          iq_pred_slot;
    logic [VLEN-1:0]     iq_pred_target;
`ifdef FRONTEND_NPC_GEN_PERF_EN
    logic [31:0]         perf_redirect;
    logic [31:0]         perf_pred_taken;
    logic [31:0]         perf_replay;
`endif

    always #5 clk = ~clk;

    frontend_npc_gen #(
        .INSTR_PER_FETCH (IPF),
        .BOOT_ADDR       (BOOT),
        .VLEN            (VLEN)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .debug_mode_i     (debug_mode),
        .redirect_valid_i (redirect),
        .redirect_addr_i  (raddr),
        .fetch_req_o      (fetch_req),
        .fetch_vaddr_o    (fetch_vaddr),
        .fetch_gnt_i      (gnt),
        .rsp_valid_i      (rsp),
        .is_jalr_i        (is_jalr),
        .btb_valid_i      (btb_valid),
        .btb_target_i     (btb_target),
        .iq_ready_i       (ready),
        .iq_valid_o       (iq_valid),
        .iq_vaddr_o       (iq_vaddr),
        .iq_pred_valid_o  (iq_pred_valid),
        .iq_pred_slot_o   (iq_pred_slot),
        .iq_pred_target_o (iq_pred_target)
`ifdef FRONTEND_NPC_GEN_PERF_EN
        ,
        .perf_redirect_o   (perf_redirect),
        .perf_pred_taken_o (perf_pred_taken),
        .perf_replay_o     (perf_replay)
`endif
    );

    // ---------------- model state ----------------
    bit          m_boot;    // first cycle after reset
    bit          m_wait;    // a granted fetch has not returned yet
    bit          m_stale;   // that outstanding fetch was overtaken by a redirect
    logic [63:0] m_pc;
    int unsigned m_cnt_redir, m_cnt_pred, m_cnt_replay;

    int n_checks = 0;
    int n_errors = 0;

    // snapshots taken at each compare point
    logic [63:0] s_req, s_vaddr, s_iq_valid, s_pred_valid, s_pred_slot, s_pred_target;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lowest live taken slot of the block starting at m_pc, from plain addresses.
    task automatic model_pred(output bit v, output int slot, output logic [63:0] tgt);
        logic [63:0] base;
        base = m_pc & ~64'(2 * IPF - 1);
        v = 1'b0; slot = 0; tgt = '0;
        for (int i = 0; i < IPF; i++) begin
            if (!v && (base + 64'(2 * i) >= m_pc) && is_jalr[i] && btb_valid[i] && !debug_mode) begin
                v    = 1'b1;
                slot = i;
                tgt  = btb_target[i*VLEN +: VLEN];
            end
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_wait = 1'b0; m_stale = 1'b0; m_pc = BOOT;
        m_cnt_redir = 0; m_cnt_pred = 0; m_cnt_replay = 0;
    endtask

    task automatic compare_outputs();
        bit          pv;
        int          ps;
        logic [63:0] pt;
        bit          acc;
        model_pred(pv, ps, pt);
        acc = rst_n && m_wait && !m_stale && rsp && ready && !redirect;
        check("fetch_req",      64'(fetch_req),      64'(!m_boot && !m_wait));
        check("fetch_vaddr",    fetch_vaddr,         m_pc);
        check("iq_valid",       64'(iq_valid),       64'(acc));
        check("iq_vaddr",       iq_vaddr,            acc ? m_pc : 64'd0);
        check("iq_pred_valid",  64'(iq_pred_valid),  64'(acc && pv));
        check("iq_pred_slot",   64'(iq_pred_slot),   (acc && pv) ? 64'(ps) : 64'd0);
        check("iq_pred_target", iq_pred_target,      (acc && pv) ? pt : 64'd0);
`ifdef FRONTEND_NPC_GEN_PERF_EN
        check("perf_redirect",   64'(perf_redirect),   64'(m_cnt_redir));
        check("perf_pred_taken", 64'(perf_pred_taken), 64'(m_cnt_pred));
        check("perf_replay",     64'(perf_replay),     64'(m_cnt_replay));
`endif
        s_req = 64'(fetch_req); s_vaddr = fetch_vaddr; s_iq_valid = 64'(iq_valid);
        s_pred_valid = 64'(iq_pred_valid); s_pred_slot = 64'(iq_pred_slot);
        s_pred_target = iq_pred_target;
    endtask

    // Advance the model over one clock edge using the inputs held across it.
    task automatic model_step();
        bit          pv;
        int          ps;
        logic [63:0] pt, npc;
        model_pred(pv, ps, pt);
        npc = pv ? pt : (m_pc & ~64'(2 * IPF - 1)) + 64'(2 * IPF);
        if (redirect) m_cnt_redir++;
        if (m_boot) begin
            m_boot = 1'b0;
            if (redirect) m_pc = raddr;
        end else if (!m_wait) begin
            if (redirect) m_pc = raddr;
            if (gnt) begin
                m_wait  = 1'b1;
                m_stale = redirect;
            end
        end else begin
            if (rsp) begin
                m_wait = 1'b0;
                if (!m_stale && !redirect) begin
                    if (ready) begin
                        m_pc = npc;
                        if (pv) m_cnt_pred++;
                    end else begin
                        m_cnt_replay++;
                    end
                end
            end
            if (redirect) begin
                m_pc = raddr;
                if (m_wait) m_stale = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic clear_inputs();
        debug_mode = 1'b0; redirect = 1'b0; raddr = '0; gnt = 1'b0; rsp = 1'b0;
        is_jalr = '0; btb_valid = '0; btb_target = '0; ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        compare_outputs();
        check("reset_vaddr_lit", fetch_vaddr, 64'h8000_0000);
        check("reset_req_lit", 64'(fetch_req), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reset, redirect to start in BOOT, grant, then return one block with
    // the given prediction inputs. Reports IQ outputs of the response cycle
    // and the address of the following request.
    task automatic run_block(input logic [63:0] start, input logic [1:0] jalr, input logic [1:0] bval,
                             input logic [63:0] tgt1, input bit dbg, input bit rdy,
                             output logic [63:0] o_iqv, output logic [63:0] o_pv,
                             output logic [63:0] o_ps, output logic [63:0] o_pt,
                             output logic [63:0] o_next);
        do_reset();
        redirect = 1'b1; raddr = start;
        tick();
        clear_inputs(); gnt = 1'b1;
        tick();
        clear_inputs();
        rsp = 1'b1; is_jalr = jalr; btb_valid = bval; btb_target = {tgt1, 64'h0000_0000_9000_0000};
        debug_mode = dbg; ready = rdy;
        tick();
        o_iqv = s_iq_valid; o_pv = s_pred_valid; o_ps = s_pred_slot; o_pt = s_pred_target;
        clear_inputs();
        tick();
        o_next = s_vaddr;
        check("run_block_req", s_req, 64'd1);
    endtask

    initial begin
        logic [63:0] iqv, pv, ps, pt, nxt;
        logic [63:0] seen [$];
        bit          first_req;

        // --- sequential fetch from boot ---
        do_reset();
        gnt = 1'b1;
        tick();
        first_req = s_req[0];
        for (int c = 0; c < 6; c++) begin
            rsp = m_wait;
            tick();
            if (s_req[0]) seen.push_back(s_vaddr);
        end
        check("boot_req_low", 64'(first_req), 64'd0);
        check("seq_addr0", (seen.size() > 0) ? seen[0] : 64'hDEAD, 64'h8000_0000);
        check("seq_addr1", (seen.size() > 1) ? seen[1] : 64'hDEAD, 64'h8000_0004);
        check("seq_addr2", (seen.size() > 2) ? seen[2] : 64'hDEAD, 64'h8000_0008);

        // --- unaligned start masks slot 0 ---
        run_block(64'h8000_0002, 2'b01, 2'b01, 64'h8000_1000, 1'b0, 1'b1, iqv, pv, ps, pt, nxt);
        check("unal_iq_valid", iqv, 64'd1);
        check("unal_pred_valid", pv, 64'd0);
        check("unal_next", nxt, 64'h8000_0004);

        // --- slot 1 taken ---
        run_block(64'h8000_0002, 2'b10, 2'b10, 64'h8000_1000, 1'b0, 1'b1, iqv, pv, ps, pt, nxt);
        check("taken_pred_valid", pv, 64'd1);
        check("taken_pred_slot", ps, 64'd1);
        check("taken_pred_target", pt, 64'h8000_1000);
        check("taken_next", nxt, 64'h8000_1000);

        // --- debug mode ignores the prediction ---
        run_block(64'h8000_0004, 2'b10, 2'b10, 64'h8000_1000, 1'b1, 1'b1, iqv, pv, ps, pt, nxt);
        check("dbg_pred_valid", pv, 64'd0);
        check("dbg_next", nxt, 64'h8000_0008);

        // --- replay when the queue is full ---
        run_block(64'h8000_0010, 2'b00, 2'b00, 64'h0, 1'b0, 1'b0, iqv, pv, ps, pt, nxt);
        check("replay_iq_valid", iqv, 64'd0);
        check("replay_next", nxt, 64'h8000_0010);

        // --- wrap at the top of the address space ---
        run_block(64'hFFFF_FFFF_FFFF_FFFC, 2'b00, 2'b00, 64'h0, 1'b0, 1'b1, iqv, pv, ps, pt, nxt);
        check("wrap_iq_valid", iqv, 64'd1);
        check("wrap_next", nxt, 64'h0);

        // --- redirect while waiting for the response ---
        do_reset();
        tick();
        gnt = 1'b1;
        tick();
        clear_inputs(); redirect = 1'b1; raddr = 64'h8000_2000;
        tick();
        clear_inputs(); rsp = 1'b1;
        tick();
        check("wait_redir_drop", s_iq_valid, 64'd0);
        clear_inputs();
        tick();
        check("wait_redir_req", s_req, 64'd1);
        check("wait_redir_addr", s_vaddr, 64'h8000_2000);

        // --- redirect coincident with grant ---
        do_reset();
        tick();
        gnt = 1'b1; redirect = 1'b1; raddr = 64'h8000_2000;
        tick();
        clear_inputs(); rsp = 1'b1;
        tick();
        check("gnt_redir_drop", s_iq_valid, 64'd0);
        clear_inputs();
        tick();
        check("gnt_redir_addr", s_vaddr, 64'h8000_2000);

`ifdef FRONTEND_NPC_GEN_PERF_EN
        // --- three redirects counted ---
        do_reset();
        redirect = 1'b1; raddr = 64'h8000_3000;
        tick();
        tick();
        tick();
        check("perf_redirect_lit", 64'(perf_redirect), 64'd3);
        clear_inputs();
`endif

        // --- randomized run, including mid-run resets ---
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 1000 == 999) do_reset();
            redirect   = ($urandom_range(7) == 0);
            if ($urandom_range(7) == 0)
                raddr = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(7) * 2);
            else
                raddr = {32'($urandom), 32'($urandom)} & ~64'd1;
            gnt        = ($urandom_range(3) != 0);
            rsp        = m_wait && ($urandom_range(1) == 1);
            ready      = ($urandom_range(3) != 0);
            debug_mode = ($urandom_range(7) == 0);
            is_jalr    = IPF'($urandom);
            btb_valid  = IPF'($urandom);
            btb_target = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frontend_npc_gen.md
Name: frontend_npc_gen

Overview:
- Next-PC generator and fetch sequencer for the frontend; consumes the per-slot BTB predictions and feeds the fetch PC back to the BTB and I-cache.
- Issues fetch requests and discards stale responses after redirects.
- Scans the returned block for a predicted-taken jalr and steers the next fetch address.
- Forwards accepted fetch blocks, with their prediction, to the instruction queue.

Parameters:
- INSTR_PER_FETCH, 2, 16-bit slots per fetch block; power of two, ≥1.
- BOOT_ADDR, 64'h0000_0000_8000_0000, first fetch address after reset.
- VLEN, 64, virtual address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- debug_mode_i  in  1  ignore BTB predictions (sequential fetch only)
- redirect_valid_i  in  1  backend redirect (mispredict/exception/eret)
- redirect_addr_i  in  VLEN  redirect target
- fetch_req_o  out  1  fetch request
- fetch_vaddr_o  out  VLEN  fetch address; also drives BTB vpc
- fetch_gnt_i  in  1  request accepted
- rsp_valid_i  in  1  fetch data returned for the last granted address
- is_jalr_i  in  INSTR_PER_FETCH  predecode: slot i holds a jalr
- btb_valid_i  in  INSTR_PER_FETCH  BTB entry valid, per slot
- btb_target_i  in  INSTR_PER_FETCH*VLEN  BTB targets, slot i at [i*VLEN +: VLEN]
- iq_ready_i  in  1  instruction queue can accept a block
- iq_valid_o  out  1  block accepted this cycle
- iq_vaddr_o  out  VLEN  address of accepted block
- iq_pred_valid_o  out  1  block contains predicted-taken jalr
- iq_pred_slot_o  out  clog2(INSTR_PER_FETCH) max 1  predicted slot index
- iq_pred_target_o  out  VLEN  predicted target

Behaviour:
- FETCH_BYTES = 2*INSTR_PER_FETCH.
- Registers:
  - pc_q: current fetch address.
  - state_q: BOOT, REQ, WAIT, DROP.
- Reset values: state_q = BOOT, pc_q = BOOT_ADDR. All outputs are 0 during reset except fetch_vaddr_o = BOOT_ADDR.
- BOOT: one cycle, fetch_req_o = 0, then goes to REQ. A redirect in BOOT loads redirect_addr_i.
- REQ:
  - fetch_req_o = 1 and fetch_vaddr_o = pc_q.
  - gnt without redirect goes to WAIT.
  - Redirect without gnt: pc_q <= redirect_addr_i, stay in REQ; the address may change while req is high only on redirect.
  - Redirect with gnt: pc_q <= redirect_addr_i, go to DROP.
- WAIT:
  - fetch_req_o = 0.
  - rsp_valid_i & iq_ready_i & !redirect: iq_valid_o = 1 (combinational), pc_q <= npc, go to REQ.
  - rsp_valid_i & !iq_ready_i & !redirect: replay. The block is dropped, pc_q is unchanged, go to REQ.
  - Redirect without rsp: pc_q <= redirect addr, go to DROP.
  - Redirect with rsp: response discarded, iq_valid_o = 0, go to REQ with the new pc.
- DROP:
  - Waits for one rsp_valid_i and discards it, then goes to REQ.
  - Further redirects in DROP only update pc_q.
- npc computation, in the accepting cycle:
  - base = pc_q with low log2(FETCH_BYTES) bits cleared.
  - Slot i is live if base + 2*i ≥ pc_q; this masks leading slots for an unaligned start.
  - Slot i is taken if live & is_jalr_i[i] & btb_valid_i[i] & !debug_mode_i.
  - The lowest taken index wins: npc = its target, iq_pred_valid_o = 1, slot and target are output.
  - No taken slot: npc = base + FETCH_BYTES, wrapping modulo 2^VLEN; pred outputs are 0.
- iq_* outputs are valid only while iq_valid_o = 1, and 0 otherwise.
- Redirect has priority over every other event in every state.
- Reset asserted mid-operation returns to BOOT immediately. Any in-flight response after reset is not tracked.

Optional Feature:
- Macro: FRONTEND_NPC_GEN_PERF_EN.
- When defined, adds outputs perf_redirect_o[31:0], perf_pred_taken_o[31:0] and perf_replay_o[31:0].
- Each is a saturating counter that resets to 0. The counters increment on:
  - a redirect_valid_i cycle;
  - an accepted block with iq_pred_valid_o set;
  - a replay event.
- When undefined, these ports and registers do not exist, and the behaviour is otherwise identical.

Decomposition:
- ariane_pkg holds:
  - the npc_state_e enum (BOOT/REQ/WAIT/DROP);
  - FETCH_BYTES derived from INSTR_PER_FETCH;
  - the npc_pred_t struct {valid, slot, target}.
- One sub-module, npc_slot_scan: combinational live-mask and lowest-taken priority encoder, returning npc_pred_t.
- The FSM and pc register live in frontend_npc_gen.

Test Plan:
- Reset release, gnt_i tied 1, rsp one cycle later, iq_ready=1, no jalr: fetch_vaddr_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; req low in BOOT cycle.
- pc=0x8000_0002 (unaligned), is_jalr=2'b01, btb_valid=2'b01: slot 0 masked, npc=0x8000_0004, iq_pred_valid_o=0. Then is_jalr=2'b10, btb_valid=2'b10, target 0x8000_1000: npc=0x8000_1000, pred_slot=1.
- Same taken prediction with debug_mode_i=1: npc=0x8000_0008, iq_pred_valid_o=0.
- rsp_valid with iq_ready=0 at pc 0x8000_0010: iq_valid_o=0, next request re-issues 0x8000_0010.
- Redirect to 0x8000_2000 in WAIT before rsp: next rsp discarded (iq_valid_o=0), following request at 0x8000_2000. Redirect coincident with gnt in REQ: state DROP, same outcome.
- pc=0xFFFF_FFFF_FFFF_FFFC, no taken slot: npc wraps to 0x0. With FRONTEND_NPC_GEN_PERF_EN, 3 redirects give perf_redirect_o=3.
